serial_tx_framer: RTL

SERIAL_TX_FRAMER -- requirements
Module: serial_tx_framer

---
 rtl/serial_pkg.sv | 17 +
 rtl/byte_fifo.sv | 60 ++++++
 rtl/serial_tx_framer.sv | 88 ++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared types and constants for the serial transmit framer
// Holds the engine state enum, the byte width and a counter-width helper.
package serial_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Width of a counter that runs 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous FIFO of DEPTH entries holding BYTE_W-bit words
// Ports: clk, rst_n (async active-low); push/wr_data write side, ignored when full;
// pop/rd_data read side, rd_data shows the head, ignored when empty;
// full, empty and level report occupancy (level runs 0..DEPTH).
module byte_fifo #(
    parameter int DEPTH  = 4,
    parameter int BYTE_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [BYTE_W-1:0]          wr_data,
    input  logic                       pop,
    output logic [BYTE_W-1:0]          rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              do_push, do_pop;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        full     = level_q == LW'(DEPTH);
        empty    = level_q == '0;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = (do_push && !do_pop) ? level_q + 1'b1 :
                   (do_pop && !do_push) ? level_q - 1'b1 : level_q;
        rd_data  = mem_q[rd_ptr_q];
        level    = level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/serial_tx_framer.sv
// serial_tx_framer: byte FIFO feeding an MSB-first serialiser with a bit-rate divider
// Ports: clk, rst_n (async active-low); in_data/in_valid/in_ready byte input handshake;
// serial_data current bit (0 when idle); shift_en one-cycle sample strobe per bit;
// byte_done pulse with the 8th shift_en; busy high in SHIFT; fifo_level queued bytes.
module serial_tx_framer import serial_pkg::*; #(
    parameter int DEPTH   = 4,
    parameter int CLK_DIV = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [BYTE_W-1:0]          in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       serial_data,
    output logic                       shift_en,
    output logic                       byte_done,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

    localparam int              DW       = cnt_w(CLK_DIV);
    localparam int              CW       = cnt_w(BYTE_W);
    localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0]   BIT_LAST = CW'(BYTE_W - 1);

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] shreg_q, shreg_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]     div_cnt_q, div_cnt_d;
    logic [BYTE_W-1:0] fifo_rd;
    logic              fifo_full, fifo_empty, pop;

    byte_fifo #(
        .DEPTH  (DEPTH),
        .BYTE_W (BYTE_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (in_valid),
        .wr_data (in_data),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Leaving SHIFT only happens on a byte boundary with nothing queued.
    always_comb begin
        state_d = (state_q == IDLE) ? (fifo_empty ? IDLE : SHIFT) :
                  (byte_done && fifo_empty) ? IDLE : SHIFT;
    end

    // Pops only from registered FIFO state, so a fresh push into an empty
    // FIFO is taken on the following edge.
    always_comb begin
        busy        = state_q == SHIFT;
        shift_en    = busy && div_cnt_q == DIV_LAST;
        byte_done   = shift_en && bit_cnt_q == BIT_LAST;
        serial_data = busy && shreg_q[BYTE_W-1];
        in_ready    = !fifo_full;
        pop         = !fifo_empty && (!busy || byte_done);
    end

    always_comb begin
        shreg_d   = pop ? fifo_rd : shift_en ? {shreg_q[BYTE_W-2:0], 1'b0} : shreg_q;
        bit_cnt_d = pop ? '0 : shift_en ? bit_cnt_q + 1'b1 : bit_cnt_q;
        div_cnt_d = (pop || shift_en || !busy) ? '0 : div_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule
